multdiv_sequencer: RTL
======================

// Module: multdiv_sequencer
// PURPOSE
//  Multi-cycle signed 32b multiply/divide controller beside the single-cycle ALU in execute.
//  FSM plus counter step one shared WIDTH+1-bit add/sub unit (sub-module) through radix-2 Booth
//  multiply or restoring divide. Reports ready/exception so the pipeline can stall on busy.
// PARAMETERS
//  WIDTH    32                  operand/result width (two's complement)
//  CNT_W    $clog2(WIDTH)       iteration counter width (derived; not overridden)
// PORTS
//  clock           in   1      single clock; all state updates on posedge
//  reset           in   1      synchronous, active-high
//  ctrl_MULT       in   1      1-cycle start pulse: A*B
//  ctrl_DIV        in   1      1-cycle start pulse: A/B (quotient only)
//  data_operandA   in   WIDTH  multiplicand / dividend, sampled with start pulse
//  data_operandB   in   WIDTH  multiplier / divisor, sampled with start pulse
//  data_result     out  WIDTH  low WIDTH bits of product, or quotient
//  data_exception  out  1      mult overflow, div-by-zero, or div overflow; valid with RDY
//  data_resultRDY  out  1      1-cycle pulse: result/exception valid
//  busy            out  1      high from cycle after start until RDY cycle inclusive
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0.
//   Reset mid-op discards the op; no RDY is produced for it.
//  States: IDLE, MULT, DIV, FIX, DONE.
//  IDLE: ctrl_MULT -> MULT; ctrl_DIV -> DIV; both high -> MULT wins, DIV dropped.
//   Operands latched on start edge. Later operand changes are ignored.
//  ctrl_* while not IDLE: ignored, no queueing.
//  MULT: reg {P_hi, P_lo=B, q_-1=0}. Each cycle: examine {P_lo[0], q_-1}.
//   01 -> P_hi+=A. 10 -> P_hi-=A. Then arithmetic shift right 1 over WIDTH+1 sign-extended bits.
//   After WIDTH iterations (counter 0..WIDTH-1) -> DONE.
//  DIV entry: B==0 -> DONE next cycle with result=0, exception=1.
//   Else take |A| and |B| as unsigned WIDTH (0x80000000 magnitude is legal); R=0, Q=|A|.
//   Each cycle: {R,Q}<<=1, trial=R-|B| on WIDTH+1 bits. trial>=0 -> R=trial, Q[0]=1.
//   After WIDTH iterations -> FIX.
//  FIX (1 cycle): if A[31]^B[31], Q=-Q (truncate toward zero).
//   exception=1 iff signs equal and Q[31]=1 (i.e. 0x80000000 / -1).
//  Mult exception: 1 iff product bits [2*WIDTH-1:WIDTH-1] are not all equal (no sign-extension fit).
//  DONE (1 cycle): data_resultRDY=1 -> IDLE.
//  data_result/data_exception hold until the next start; they are cleared to 0 in the start cycle.
//  Latency from start edge t to RDY high:
//   MULT t+WIDTH+1 (33); DIV t+WIDTH+2 (34); div-by-zero t+1.
//   Back-to-back: a new start is accepted in the cycle after RDY.
//  Shared adder: exactly one consumer per cycle, enforced by state; inputs are 0 in IDLE/DONE.
//   Carry-in=1 for subtract.
// STRUCTURE
//  Package multdiv_pkg: WIDTH, state encodings (IDLE=0, MULT=1, DIV=2, FIX=3, DONE=4, 3b),
//   op enum {OP_MULT, OP_DIV}.
//  Sub-module multdiv_addsub: WIDTH+1-bit combinational a +/- b, sub select, sign/overflow out.
//   Instantiated once and muxed by state.
//  Top contains: FSM, CNT_W+1 counter, 2*WIDTH+1 product/remainder-quotient register,
//   latched sign bits, exception logic.
// TESTING
//  1 A=7, B=-3, MULT pulse at cycle 0 -> RDY only at cycle 33; result=0xFFFFFFEB, exc=0, busy 1..33.
//  2 A=0x40000000, B=4, MULT -> result=0x00000000, exc=1; A=-1, B=-1 -> result=1, exc=0.
//  3 A=-100, B=7, DIV -> RDY at cycle 34, result=0xFFFFFFF2 (-14), exc=0; A=100, B=-7 -> -14.
//  4 A=5, B=0, DIV -> RDY at cycle 1, result=0, exc=1; then A=0x80000000, B=-1 -> 0x80000000, exc=1.
//  5 MULT start, then ctrl_DIV at cycle 5 and operand changes -> ignored, MULT result correct.
//   Both ctrl high in IDLE -> MULT performed.
//  6 reset at cycle 10 of a DIV -> next cycle all outputs 0, no RDY.
//   New MULT 6*7 at cycle 12 -> 42 at cycle 45.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared width, FSM encodings and op selector for the multi-cycle multiply/divide unit.
package multdiv_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MULT = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_e;

endpackage

// File: rtl/multdiv_addsub.sv
// Combinational W-bit add/subtract shared by every datapath step of the sequencer.
module multdiv_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic [W-1:0] o_sum,
    output logic         o_sign,
    output logic         o_ovf
);

    assign o_sum  = i_a + (i_sub ? ~i_b : i_b) + {{(W-1){1'b0}}, i_sub};
    assign o_sign = o_sum[W-1];
    // Set when the result no longer fits in the low W-1 bits as a signed value.
    assign o_ovf  = o_sum[W-1] ^ o_sum[W-2];

endmodule

// File: rtl/multdiv_sequencer.sv
// Signed multi-cycle multiply (radix-2 Booth) and divide (restoring) sequencer
// driving one shared add/sub unit; the pipeline stalls on busy.
module multdiv_sequencer
    import multdiv_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int PW    = 2 * WIDTH + 1;
    localparam logic [CNT_W:0] CNT_LAST = (CNT_W + 1)'(WIDTH - 1);
    localparam logic [CNT_W:0] CNT_ONE  = (CNT_W + 1)'(1);

    state_e           r_state, w_next;
    logic [CNT_W:0]   r_cnt;
    logic [PW-1:0]    r_acc;
    logic [WIDTH-1:0] r_opnd, r_result;
    logic             r_sa, r_sb, r_exc;

    logic             w_start, w_last, w_q, w_sub, w_sign, w_ovf;
    op_e              w_op;
    logic [WIDTH-1:0] w_abs_a, w_abs_b, w_hi, w_lo, w_rem_sh, w_quo;
    logic [WIDTH:0]   w_add_a, w_add_b, w_sum, w_top;
    logic [PW-1:0]    w_mul_next, w_div_next;

    assign w_start  = (r_state == S_IDLE) && (ctrl_MULT || ctrl_DIV);
    assign w_op     = ctrl_MULT ? OP_MULT : OP_DIV;
    assign w_abs_a  = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign w_abs_b  = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    assign w_last   = (r_cnt == CNT_LAST);

    // Multiply view of r_acc: {P_hi, P_lo, q_-1}; divide view: {-, R, Q}.
    assign w_hi     = r_acc[PW-1:WIDTH+1];
    assign w_lo     = r_acc[WIDTH:1];
    assign w_q      = r_acc[0];
    assign w_rem_sh = r_acc[2*WIDTH-2:WIDTH-1];
    assign w_quo    = r_acc[WIDTH-1:0];

    always_comb begin
        w_add_a = '0;
        w_add_b = '0;
        w_sub   = 1'b0;
        case (r_state)
            S_MULT: begin
                w_add_a = {w_hi[WIDTH-1], w_hi};
                case ({w_lo[0], w_q})
                    2'b01:   w_add_b = {r_opnd[WIDTH-1], r_opnd};
                    2'b10: begin
                        w_add_b = {r_opnd[WIDTH-1], r_opnd};
                        w_sub   = 1'b1;
                    end
                    default: w_add_b = '0;
                endcase
            end
            S_DIV: begin
                w_add_a = {1'b0, w_rem_sh};
                w_add_b = {1'b0, r_opnd};
                w_sub   = 1'b1;
            end
            S_FIX: begin
                // 0 +/- Q: overflow flags a positive quotient with bit 31 set.
                w_add_b = {1'b0, w_quo};
                w_sub   = r_sa ^ r_sb;
            end
            default: ;
        endcase
    end

    multdiv_addsub #(.W(WIDTH + 1)) u_addsub (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_sub  (w_sub),
        .o_sum  (w_sum),
        .o_sign (w_sign),
        .o_ovf  (w_ovf)
    );

    assign w_mul_next = {w_sum, w_lo};
    assign w_div_next = {1'b0, (w_sign ? w_rem_sh : w_sum[WIDTH-1:0]), w_quo[WIDTH-2:0], ~w_sign};
    assign w_top      = w_mul_next[PW-1:WIDTH];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (w_op == OP_MULT)             w_next = S_MULT;
                    else if (data_operandB == '0)    w_next = S_DONE;
                    else                             w_next = S_DIV;
                end
            end
            S_MULT:  if (w_last) w_next = S_DONE;
            S_DIV:   if (w_last) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_cnt    <= '0;
                        r_result <= '0;
                        r_exc    <= (w_op == OP_DIV) && (data_operandB == '0);
                        r_sa     <= data_operandA[WIDTH-1];
                        r_sb     <= data_operandB[WIDTH-1];
                        if (w_op == OP_MULT) begin
                            r_opnd <= data_operandA;
                            r_acc  <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
                        end else begin
                            r_opnd <= w_abs_b;
                            r_acc  <= {{(WIDTH+1){1'b0}}, w_abs_a};
                        end
                    end
                end
                S_MULT: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt + CNT_ONE;
                    if (w_last) begin
                        r_result <= w_mul_next[WIDTH:1];
                        r_exc    <= ~((&w_top) | ~(|w_top));
                    end
                end
                S_DIV: begin
                    r_acc <= w_div_next;
                    r_cnt <= r_cnt + CNT_ONE;
                end
                S_FIX: begin
                    r_result <= w_sum[WIDTH-1:0];
                    r_exc    <= w_ovf;
                end
                default: ;
            endcase
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = (r_state == S_DONE);
    assign busy           = (r_state != S_IDLE);

endmodule
